// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-granular arbiter that shares one uart_tx byte transmitter
// between NUM_REQ byte-stream requesters and paces bytes from tx_busy.
module uart_tx_arbiter #(
  parameter int         NUM_REQ   = 4,
  parameter logic [7:0] BUSY_WAIT = 8'd16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   grant,
  output logic [7:0]           tx_data,
  output logic                 tx_pluse,
  input  logic                 tx_busy,
  output logic                 active
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_PULSE,
    S_WAIT_HI,
    S_WAIT_LO
  } state_t;

  state_t             r_state;
  logic [IDX_W-1:0]   r_owner;
  logic [IDX_W-1:0]   r_rr_ptr;
  logic               r_last_flag;
  logic [7:0]         r_wait_cnt;
  logic [NUM_REQ-1:0] r_grant;
  logic [7:0]         r_tx_data;
  logic               r_tx_pluse;
  logic               r_active;

  logic [IDX_W-1:0]   w_pick_idx;
  logic               w_own_vld;
  logic [7:0]         w_own_data;
  logic               w_own_last;

  // First valid index at or above ptr, wrapping modulo NUM_REQ.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] vld,
                                               input logic [IDX_W-1:0]   ptr);
    logic [IDX_W-1:0] sel;
    logic [IDX_W-1:0] p;
    int               pos;
    sel = ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      pos = (int'(ptr) + k) % NUM_REQ;
      p   = IDX_W'(pos);
      if (vld[p]) sel = p;
    end
    return sel;
  endfunction

  assign w_pick_idx = rr_pick(req_valid, r_rr_ptr);

  always_comb begin
    w_own_vld  = 1'b0;
    w_own_data = 8'h00;
    w_own_last = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_grant[i]) begin
        w_own_vld  = req_valid[i];
        w_own_data = req_data[8*i +: 8];
        w_own_last = req_last[i];
      end
    end
  end

  // The accept strobe must coincide with the edge that captures the byte, so it
  // is decoded from the LOAD state rather than registered.
  assign req_ready = (r_state == S_LOAD) ? (r_grant & req_valid) : '0;
  assign grant     = r_grant;
  assign tx_data   = r_tx_data;
  assign tx_pluse  = r_tx_pluse;
  assign active    = r_active;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_owner     <= '0;
      r_rr_ptr    <= '0;
      r_last_flag <= 1'b0;
      r_wait_cnt  <= 8'h00;
      r_grant     <= '0;
      r_tx_data   <= 8'h00;
      r_tx_pluse  <= 1'b0;
      r_active    <= 1'b0;
    end else begin
      r_tx_pluse <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!tx_busy && (|req_valid)) begin
            r_owner  <= w_pick_idx;
            r_grant  <= NUM_REQ'(1) << w_pick_idx;
            r_active <= 1'b1;
            r_state  <= S_LOAD;
          end
        end
        S_LOAD: begin
          // Packet lock: an owner without a byte stalls everybody.
          if (w_own_vld) begin
            r_tx_data   <= w_own_data;
            r_last_flag <= w_own_last;
            r_tx_pluse  <= 1'b1;
            r_state     <= S_PULSE;
          end
        end
        S_PULSE: begin
          r_wait_cnt <= 8'h00;
          r_state    <= S_WAIT_HI;
        end
        S_WAIT_HI: begin
          // A busy that never shows up must not hang the arbiter.
          if (tx_busy || (r_wait_cnt == BUSY_WAIT - 8'd1)) begin
            r_state <= S_WAIT_LO;
          end else begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
          end
        end
        S_WAIT_LO: begin
          if (!tx_busy) begin
            if (r_last_flag) begin
              r_grant  <= '0;
              r_rr_ptr <= (r_owner == IDX_W'(NUM_REQ - 1)) ? '0 : r_owner + 1'b1;
              r_active <= 1'b0;
              r_state  <= S_IDLE;
            end else begin
              r_state <= S_LOAD;
            end
          end
        end
        default: begin
          r_grant  <= '0;
          r_active <= 1'b0;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule
